reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Generates the synchronous, active-high `sync_reset` that feeds `dff_sync_reset` and the other sync-reset flops in the design.
- Takes the board-level asynchronous active-low reset and an in-domain software reset request.
- Produces a reset that asserts immediately, deasserts cleanly on a clock edge, and is held for a programmable number of cycles.
- Also reports when the domain is out of reset.

Parameters:
- SYNC_STAGES, 2, number of flops in the reset-deassertion synchroniser chain; legal range 2..4.
- HOLD_CYCLES, 16, number of clk cycles `sync_reset` stays high after the synchroniser releases or after a software request; legal range >= 1.
- CNT_W, $clog2(HOLD_CYCLES+1), hold counter width; derived, do not override.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- async_reset_n  input  1  asynchronous active-low reset; asserts without a clock, deasserts through the synchroniser.
- sw_reset_req  input  1  synchronous to clk, active-high software reset request; level-sensitive.
- sync_reset  output  1  active-high synchronous reset to downstream flops; registered.
- reset_done  output  1  high while the domain is in normal operation (FSM in RUN); registered.
- done_pulse  output  1  one-cycle pulse on the cycle `reset_done` rises.

Behaviour:
- Interface: one clock, `clk`. Reset `async_reset_n` is asynchronous and active-low.
- Values while `async_reset_n`=0, with no clock needed:
  - sync chain = all 0
  - FSM = ASSERT
  - counter = 0
  - `sync_reset` = 1
  - `reset_done` = 0
  - `done_pulse` = 0
- Synchroniser:
  - chain of SYNC_STAGES flops, constant 1 shifted in, cleared asynchronously by `async_reset_n`.
  - `rst_sync` is the last stage.
- FSM states: ASSERT, HOLD, RUN.
  - ASSERT: `sync_reset`=1. When `rst_sync`=1, go to HOLD and load the counter.
  - HOLD: `sync_reset`=1, counter counts down. On terminal count, go to RUN. If `sw_reset_req`=1, reload the counter and stay in HOLD.
  - RUN: `sync_reset`=0, `reset_done`=1. If `sw_reset_req`=1, go to HOLD and reload the counter.
- Power-up latency: `async_reset_n` sampled high at rising edge E1 → `sync_reset` falls after edge E(SYNC_STAGES+HOLD_CYCLES). With defaults this is E18. `reset_done` and `done_pulse` rise at the same edge.
- Software reset:
  - A one-cycle `sw_reset_req` sampled at edge k in RUN gives `sync_reset`=1 after edge k, for exactly HOLD_CYCLES cycles; it falls after edge k+HOLD_CYCLES.
  - `reset_done` falls after edge k.
- `sw_reset_req` held high: `sync_reset` stays high. Release at edge m (req sampled 0) → `sync_reset` falls after edge m+HOLD_CYCLES-1. The count restarts from the last sampled-high edge.
- `sw_reset_req` is ignored in ASSERT; the hardware reset dominates.
- `async_reset_n` falling mid-HOLD or mid-RUN: all outputs return to reset values immediately, and the full power-up sequence reruns.
- An `async_reset_n` glitch shorter than one clock still clears the chain and restarts the full sequence.
- `done_pulse` is exactly one cycle per ASSERT/HOLD→RUN transition. It is never high while `sync_reset`=1.
- Invariant: `sync_reset` == !`reset_done` at all times.
- Outputs come straight from flops; no combinational path from any input to any output, except the asynchronous clear.

Decomposition:
- Shared package/include `rst_seq_pkg`:
  - state encodings ASSERT=2'd0, HOLD=2'd1, RUN=2'd2.
  - 2'd3 is illegal and recovers to ASSERT.
- One natural sub-module: `reset_sync_chain` (SYNC_STAGES-deep async-assert/sync-deassert flop chain). It is reusable by other clock domains.

Test Plan:
- Power-up: `async_reset_n`=0 for 3 cycles, then 1 → `sync_reset`=1 through edge 17 after release, 0 after edge 18; `done_pulse` high exactly one cycle there.
- Async assert mid-RUN: drop `async_reset_n` between edges → `sync_reset`=1 and `reset_done`=0 before the next edge; on release, 18-edge sequence repeats.
- Single-cycle `sw_reset_req` in RUN at edge k → `sync_reset` high for exactly 16 cycles, low after k+16, one `done_pulse`.
- `sw_reset_req` held for 5 cycles → `sync_reset` high for 5+15=20 cycles total; no `done_pulse` until release+15 edges.
- `sw_reset_req`=1 during power-up ASSERT/HOLD → ignored in ASSERT, extends HOLD; `sync_reset` never glitches low.
- Downstream hookup: drive `dff_sync_reset` with `sync_reset` while toggling d → q held at 0 until `sync_reset` falls, then follows d one cycle later; also rerun with SYNC_STAGES=3, HOLD_CYCLES=1 → release after edge 4.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// FSM encodings and hold-counter preload values.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        HOLD   = 2'd1,
        RUN    = 2'd2
    } state_e;

    // The ASSERT->HOLD edge already counts as one held cycle,
    // so the hardware path preloads one less than a software request.
    function automatic int unsigned hold_preload(
        input int unsigned hold_cycles,
        input logic        from_sw
    );
        if (from_sw)
            return hold_cycles - 1;
        else if (hold_cycles > 1)
            return hold_cycles - 2;
        else
            return 0;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Software request in, domain reset status out.
// master: sequencer side, slave: consumer side.
interface reset_sequencer_if;

    logic sw_reset_req;
    logic sync_reset;
    logic reset_done;
    logic done_pulse;

    modport master (
        input  sw_reset_req,
        output sync_reset,
        output reset_done,
        output done_pulse
    );

    modport slave (
        output sw_reset_req,
        input  sync_reset,
        input  reset_done,
        input  done_pulse
    );

endinterface

// File: rtl/reset_sync_chain.sv
// Async-assert / sync-deassert reset synchroniser.
// Reusable in any clock domain; output is the last stage.
module reset_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic async_reset_n,
    output logic rst_sync
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n)
            chain <= '0;
        else
            chain <= {chain[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Domain reset sequencer: synchronised release, programmable hold,
// software reset requests and a done pulse, all outputs registered.
module reset_sequencer #(
    parameter  int SYNC_STAGES = 2,
    parameter  int HOLD_CYCLES = 16,
    localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               async_reset_n,
    reset_sequencer_if.master  rif
);

    import rst_seq_pkg::*;

    localparam logic [CNT_W-1:0] LOAD_HW =
        CNT_W'(hold_preload(HOLD_CYCLES, 1'b0));
    localparam logic [CNT_W-1:0] LOAD_SW =
        CNT_W'(hold_preload(HOLD_CYCLES, 1'b1));

    state_e           state;
    state_e           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             rst_sync;
    logic             sync_reset_q;
    logic             reset_done_q;
    logic             done_pulse_q;

    reset_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .rst_sync      (rst_sync)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ASSERT: begin
                if (rst_sync) begin
                    if (HOLD_CYCLES == 1) begin
                        state_n = RUN;
                    end else begin
                        state_n = HOLD;
                        cnt_n   = LOAD_HW;
                    end
                end
            end
            HOLD: begin
                if (rif.sw_reset_req)
                    cnt_n = LOAD_SW;
                else if (cnt == '0)
                    state_n = RUN;
                else
                    cnt_n = cnt - 1'b1;
            end
            RUN: begin
                if (rif.sw_reset_req) begin
                    state_n = HOLD;
                    cnt_n   = LOAD_SW;
                end
            end
            default: begin
                state_n = ASSERT;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so they change
    // on the same edge as the FSM, straight from flops.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state        <= ASSERT;
            cnt          <= '0;
            sync_reset_q <= 1'b1;
            reset_done_q <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            sync_reset_q <= (state_n != RUN);
            reset_done_q <= (state_n == RUN);
            done_pulse_q <= (state_n == RUN) && (state != RUN);
        end
    end

    assign rif.sync_reset = sync_reset_q;
    assign rif.reset_done = reset_done_q;
    assign rif.done_pulse = done_pulse_q;

endmodule
